// File: rtl/fifo_wr_gen.sv
// fifo_wr_gen: write-side burst stimulus generator for FIFO test designs.
// Waits for a synchronised empty, then writes a patterned sequence until almost_full/full.
module fifo_wr_gen #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned WRAP_VAL  = 254,
    parameter int unsigned SYNC_STG  = 2,
    parameter int unsigned LFSR_SEED = 1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              wr_clk,
    input  logic              rst_n,
    input  logic              wr_rst_busy,
    input  logic              empty,
    input  logic              almost_full,
    input  logic              full,
    input  logic              gen_en,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_val,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              burst_done,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              ovf_err
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_EMPTY = 2'd1,
        ST_WRITE      = 2'd2
    } state_e;

    localparam logic [1:0] MODE_INCR  = 2'b00;
    localparam logic [1:0] MODE_DECR  = 2'b01;
    localparam logic [1:0] MODE_LFSR  = 2'b10;
    localparam logic [1:0] MODE_CONST = 2'b11;

    localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [DATA_W-1:0] WRAP_V    = DATA_W'(WRAP_VAL);
    // An all-zero seed would lock the LFSR, so it is forced to 1.
    localparam logic [DATA_W-1:0] SEED_V    = (LFSR_SEED == 32'd0) ? DATA_ONE : DATA_W'(LFSR_SEED);

    localparam logic [31:0] LFSR_TAPS32 = (DATA_W == 32'd16) ? 32'h0000_B400 :
                                          (DATA_W == 32'd32) ? 32'h8020_0003 :
                                                               32'h0000_00B8;
    localparam logic [DATA_W+31:0] LFSR_TAPS_EXT = {{DATA_W{1'b0}}, LFSR_TAPS32};
    localparam logic [DATA_W-1:0]  LFSR_TAPS     = LFSR_TAPS_EXT[DATA_W-1:0];

    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] shifted;
        shifted = {1'b0, d[DATA_W-1:1]};
        if (d[0]) begin
            lfsr_next = shifted ^ LFSR_TAPS;
        end else begin
            lfsr_next = shifted;
        end
    endfunction

    function automatic logic [DATA_W-1:0] pattern_next(input logic [1:0] m, input logic [DATA_W-1:0] d);
        case (m)
            MODE_INCR: pattern_next = (d == WRAP_V) ? DATA_ZERO : d + DATA_ONE;
            MODE_DECR: pattern_next = (d == DATA_ZERO) ? WRAP_V : d - DATA_ONE;
            MODE_LFSR: pattern_next = lfsr_next(d);
            default:   pattern_next = d;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [SYNC_STG-1:0] empty_sync_q;
    logic                empty_s;
    logic [1:0]          mode_q, mode_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                burst_done_q, burst_done_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic                ovf_q, ovf_d;

    assign empty_s = empty_sync_q[SYNC_STG-1];

    // Synchroniser for the read-domain empty flag.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            empty_sync_q <= {SYNC_STG{1'b0}};
        end else begin
            empty_sync_q <= {empty_sync_q[SYNC_STG-2:0], empty};
        end
    end

    // FSM next state, registered-output targets and pattern sequencing.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        data_d       = data_q;
        if (wr_rst_busy || !gen_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_EMPTY;
                ST_WAIT_EMPTY: begin
                    if (!full && !almost_full && empty_s) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_WAIT_EMPTY;
                    end
                end
                ST_WRITE: begin
                    if (full || almost_full) begin
                        state_d = ST_WAIT_EMPTY;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        wr_en_d      = (state_d == ST_WRITE);
        burst_done_d = (state_q == ST_WRITE) && (state_d != ST_WRITE);

        // Mode is only re-sampled outside a burst so a burst never mixes patterns.
        if ((state_q != ST_WRITE) && (mode != mode_q)) begin
            mode_d = mode;
            case (mode)
                MODE_INCR: data_d = DATA_ZERO;
                MODE_DECR: data_d = DATA_ZERO;
                MODE_LFSR: data_d = SEED_V;
                default:   data_d = const_val;
            endcase
        end else if (mode_q == MODE_CONST) begin
            data_d = const_val;
        end else if (wr_en_q) begin
            data_d = pattern_next(mode_q, data_q);
        end else begin
            data_d = data_q;
        end

        word_cnt_d = wr_en_q ? (word_cnt_q + CNT_ONE) : word_cnt_q;
        ovf_d      = ovf_q | (wr_en_q & full);
    end

    // State and output registers.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_INCR;
            wr_en_q      <= 1'b0;
            data_q       <= DATA_ZERO;
            burst_done_q <= 1'b0;
            word_cnt_q   <= {CNT_W{1'b0}};
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            wr_en_q      <= wr_en_d;
            data_q       <= data_d;
            burst_done_q <= burst_done_d;
            word_cnt_q   <= word_cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = data_q;
    assign burst_done   = burst_done_q;
    assign word_cnt     = word_cnt_q;
    assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_fifo_wr_gen.sv
// Directed self-checking bench for fifo_wr_gen (DATA_W=8, WRAP_VAL=254, SYNC_STG=2).
module tb_fifo_wr_gen;

    logic        wr_clk = 1'b0;
    logic        rst_n;
    logic        wr_rst_busy;
    logic        empty;
    logic        almost_full;
    logic        full;
    logic        gen_en;
    logic [1:0]  mode;
    logic [7:0]  const_val;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        burst_done;
    logic [31:0] word_cnt;
    logic        ovf_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] seen[$];
    logic [7:0] wrap_exp [4] = '{8'd253, 8'd254, 8'd0, 8'd1};
    logic [7:0] decr_exp [4] = '{8'd0, 8'd254, 8'd253, 8'd252};
    bit         hit [256];

    fifo_wr_gen #(
        .DATA_W(8), .WRAP_VAL(254), .SYNC_STG(2), .LFSR_SEED(1), .CNT_W(32)
    ) dut (
        .wr_clk(wr_clk), .rst_n(rst_n), .wr_rst_busy(wr_rst_busy), .empty(empty),
        .almost_full(almost_full), .full(full), .gen_en(gen_en), .mode(mode),
        .const_val(const_val), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .burst_done(burst_done), .word_cnt(word_cnt), .ovf_err(ovf_err)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    // Presents empty, collects nwords written words, then raises almost_full like a real FIFO.
    task automatic run_burst(input int nwords);
        int got = 0;
        int cyc = 0;
        seen.delete();
        almost_full = 1'b0;
        empty       = 1'b1;
        while (got < nwords && cyc < nwords + 20) begin
            step();
            cyc++;
            if (fifo_wr_en) begin
                seen.push_back(fifo_wr_data);
                got++;
                if (got == nwords) begin
                    almost_full = 1'b1;
                    empty       = 1'b0;
                end
            end
        end
        check_val("burst_words", 32'(got), 32'(nwords));
        step();
        check_val("wr_en_fall", 32'(fifo_wr_en), 32'd0);
        check_val("burst_done", 32'(burst_done), 32'd1);
        step();
        check_val("burst_done_once", 32'(burst_done), 32'd0);
        almost_full = 1'b0;
    endtask

    task automatic abort_check(input bit by_busy, input logic [7:0] resume);
        if (by_busy) wr_rst_busy = 1'b1;
        else         gen_en      = 1'b0;
        step();
        check_val("abort_wr_en", 32'(fifo_wr_en), 32'd0);
        check_val("abort_done", 32'(burst_done), 32'd1);
        step();
        check_val("abort_done_once", 32'(burst_done), 32'd0);
        check_val("abort_idle", 32'(fifo_wr_en), 32'd0);
        wr_rst_busy = 1'b0;
        gen_en      = 1'b1;
        step();
        check_val("abort_via_idle", 32'(fifo_wr_en), 32'd0);
        step();
        check_val("abort_resume_en", 32'(fifo_wr_en), 32'd1);
        check_val("abort_resume_data", 32'(fifo_wr_data), 32'(resume));
    endtask

    initial begin
        int dup;
        int cyc;
        rst_n = 1'b0; wr_rst_busy = 1'b0; empty = 1'b0; almost_full = 1'b0;
        full = 1'b0; gen_en = 1'b0; mode = 2'b00; const_val = 8'hA5;
        step();
        step();
        check_val("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check_val("rst_data", 32'(fifo_wr_data), 32'd0);
        check_val("rst_done", 32'(burst_done), 32'd0);
        check_val("rst_cnt", word_cnt, 32'd0);
        check_val("rst_ovf", 32'(ovf_err), 32'd0);
        rst_n  = 1'b1;
        gen_en = 1'b1;

        // T2 incrementing fill of 20 words.
        run_burst(20);
        for (int i = 0; i < 20; i++) check_val("t2_data", 32'(seen[i]), 32'(i));
        check_val("t2_cnt", word_cnt, 32'd20);

        // T3 wrap at 254 and continuity across bursts.
        run_burst(233);
        for (int i = 0; i < 233; i++) check_val("t3_seq", 32'(seen[i]), 32'(20 + i));
        run_burst(4);
        for (int i = 0; i < 4; i++) check_val("t3_wrap", 32'(seen[i]), 32'(wrap_exp[i]));
        run_burst(2);
        check_val("t3_resume0", 32'(seen[0]), 32'd2);
        check_val("t3_resume1", 32'(seen[1]), 32'd3);
        check_val("t3_cnt", word_cnt, 32'd259);

        // T4 decrement from 0 with wrap to 254.
        mode = 2'b01;
        step();
        run_burst(4);
        for (int i = 0; i < 4; i++) check_val("t4_decr", 32'(seen[i]), 32'(decr_exp[i]));

        // T4 LFSR: seed 1, 255-long period, never zero.
        mode = 2'b10;
        step();
        run_burst(256);
        check_val("lfsr_first", 32'(seen[0]), 32'h01);
        check_val("lfsr_second", 32'(seen[1]), 32'hB8);
        check_val("lfsr_third", 32'(seen[2]), 32'h5C);
        dup = 0;
        for (int i = 0; i < 255; i++) begin
            if (hit[seen[i]]) dup++;
            hit[seen[i]] = 1'b1;
        end
        check_val("lfsr_distinct", 32'(dup), 32'd0);
        check_val("lfsr_no_zero", 32'(hit[0]), 32'd0);
        check_val("lfsr_period", 32'(seen[255]), 32'h01);

        // Constant mode.
        mode = 2'b11;
        step();
        run_burst(3);
        for (int i = 0; i < 3; i++) check_val("const_data", 32'(seen[i]), 32'hA5);
        check_val("t4_cnt", word_cnt, 32'd522);

        // T5 abort by wr_rst_busy, then by gen_en=0.
        mode = 2'b00;
        step();
        empty = 1'b1;
        cyc = 0;
        while (!fifo_wr_en && cyc < 20) begin
            step();
            cyc++;
        end
        check_val("t5_start", 32'(fifo_wr_en), 32'd1);
        check_val("t5_d0", 32'(fifo_wr_data), 32'd0);
        step();
        step();
        check_val("t5_d2", 32'(fifo_wr_data), 32'd2);
        abort_check(1'b1, 8'd3);
        abort_check(1'b0, 8'd4);

        // T6 full without almost_full.
        check_val("ovf_pre", 32'(ovf_err), 32'd0);
        full = 1'b1;
        step();
        check_val("ovf_set", 32'(ovf_err), 32'd1);
        check_val("ovf_wr_en", 32'(fifo_wr_en), 32'd0);
        check_val("ovf_done", 32'(burst_done), 32'd1);
        full = 1'b0;
        step();
        check_val("ovf_wait_restart", 32'(fifo_wr_en), 32'd1);
        check_val("ovf_data", 32'(fifo_wr_data), 32'd5);
        step();
        check_val("ovf_sticky", 32'(ovf_err), 32'd1);

        // T1 asynchronous reset mid-burst.
        check_val("t1_pre_en", 32'(fifo_wr_en), 32'd1);
        rst_n = 1'b0;
        #2;
        check_val("t1_wr_en", 32'(fifo_wr_en), 32'd0);
        check_val("t1_data", 32'(fifo_wr_data), 32'd0);
        check_val("t1_done", 32'(burst_done), 32'd0);
        check_val("t1_cnt", word_cnt, 32'd0);
        check_val("t1_ovf", 32'(ovf_err), 32'd0);
        rst_n = 1'b1;
        step();
        check_val("t1_no_write1", 32'(fifo_wr_en), 32'd0);
        step();
        check_val("t1_no_write2", 32'(fifo_wr_en), 32'd0);
        step();
        check_val("t1_restart", 32'(fifo_wr_en), 32'd1);
        check_val("t1_restart_data", 32'(fifo_wr_data), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
